// File: rtl/wide_add_sched_pkg.sv
// Shared types and constants for the two-cycle 128-bit add/subtract scheduler.
package wide_add_sched_pkg;

  localparam int unsigned HALF_W = 64;
  localparam int unsigned FULL_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Latched operation; b is stored already inverted for subtraction.
  typedef struct packed {
    logic [FULL_W-1:0] a;
    logic [FULL_W-1:0] b;
    logic              sub;
    logic              src;
  } op_t;

  function automatic logic carry_combine(input logic g, input logic p, input logic c);
    return g | (p & c);
  endfunction

endpackage

// File: rtl/wide_add_sched_if.sv
// Request/response bundle between the two requesters, the consumer and the scheduler.
interface wide_add_sched_if;
  import wide_add_sched_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [FULL_W-1:0] req0_a;
  logic [FULL_W-1:0] req0_b;
  logic              req0_sub;

  logic              req1_valid;
  logic              req1_ready;
  logic [FULL_W-1:0] req1_a;
  logic [FULL_W-1:0] req1_b;
  logic              req1_sub;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_src;
  logic [FULL_W-1:0] rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    output rsp_valid, rsp_src, rsp_sum, rsp_cout, rsp_ovf,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    input  rsp_valid, rsp_src, rsp_sum, rsp_cout, rsp_ovf,
    output rsp_ready
  );

endinterface

// File: rtl/sixtyfourbit_lca.sv
// 64-bit lookahead-carry adder slice (parallel-prefix) exporting group generate/propagate.
module sixtyfourbit_lca
  import wide_add_sched_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              c,
  output logic [HALF_W-1:0] s,
  output logic              g,
  output logic              p
);

  logic [HALF_W-1:0] bit_g;
  logic [HALF_W-1:0] bit_p;
  logic [HALF_W-1:0] grp_g;
  logic [HALF_W-1:0] grp_p;

  // Kogge-Stone prefix; walking i downward keeps grp_*[i-d] at the previous level.
  always_comb begin
    bit_g = a & b;
    bit_p = a ^ b;
    grp_g = bit_g;
    grp_p = bit_p;
    s     = '0;
    for (int d = 1; d < int'(HALF_W); d = d * 2) begin
      for (int i = int'(HALF_W) - 1; i >= d; i--) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        grp_p[i] = grp_p[i] & grp_p[i-d];
      end
    end
    s[0] = bit_p[0] ^ c;
    for (int i = 1; i < int'(HALF_W); i++) begin
      s[i] = bit_p[i] ^ (grp_g[i-1] | (grp_p[i-1] & c));
    end
  end

  assign g = grp_g[HALF_W-1];
  assign p = grp_p[HALF_W-1];

endmodule

// File: rtl/wide_add_sched.sv
// Two-requester scheduler running 128-bit add/sub as low then high passes over one 64-bit adder.
module wide_add_sched
  import wide_add_sched_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  wide_add_sched_if.slave  bus
);

  state_e            state_q;
  state_e            state_d;
  op_t               op_q;
  op_t               op_d;
  logic              last_grant_q;
  logic              c64_q;
  logic [HALF_W-1:0] sum_lo_q;

  logic              grant0_c;
  logic              grant1_c;
  logic              rsp_hs_c;
  logic [HALF_W-1:0] add_a_c;
  logic [HALF_W-1:0] add_b_c;
  logic [HALF_W-1:0] add_s_c;
  logic              add_cin_c;
  logic              add_g_c;
  logic              add_p_c;
  logic              add_cout_c;

  // Requester 0 wins unless requester 1 is also pending and it is requester 1's turn.
  assign grant0_c = bus.req0_valid & (~bus.req1_valid | last_grant_q | ~RR_EN);
  assign grant1_c = bus.req1_valid & ~grant0_c;
  assign rsp_hs_c = bus.rsp_valid & bus.rsp_ready;

  assign bus.req0_ready = ~rst & (state_q == ST_IDLE) & grant0_c;
  assign bus.req1_ready = ~rst & (state_q == ST_IDLE) & grant1_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant0_c | grant1_c) state_d = ST_LO;
      ST_LO:   state_d = ST_HI;
      ST_HI:   state_d = ST_RESP;
      ST_RESP: if (rsp_hs_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the granted operation, pre-inverting b for subtraction.
  always_comb begin
    op_d = op_q;
    if (state_q == ST_IDLE && grant0_c) begin
      op_d = '{a: bus.req0_a, b: bus.req0_sub ? ~bus.req0_b : bus.req0_b,
               sub: bus.req0_sub, src: 1'b0};
    end else if (state_q == ST_IDLE && grant1_c) begin
      op_d = '{a: bus.req1_a, b: bus.req1_sub ? ~bus.req1_b : bus.req1_b,
               sub: bus.req1_sub, src: 1'b1};
    end
  end

  // Low half takes cin = sub; high half takes the registered carry out of bit 63.
  always_comb begin
    add_a_c   = op_q.a[HALF_W-1:0];
    add_b_c   = op_q.b[HALF_W-1:0];
    add_cin_c = op_q.sub;
    if (state_q == ST_HI) begin
      add_a_c   = op_q.a[FULL_W-1:HALF_W];
      add_b_c   = op_q.b[FULL_W-1:HALF_W];
      add_cin_c = c64_q;
    end
    add_cout_c = carry_combine(add_g_c, add_p_c, add_cin_c);
  end

  sixtyfourbit_lca u_lca (
    .a (add_a_c),
    .b (add_b_c),
    .c (add_cin_c),
    .s (add_s_c),
    .g (add_g_c),
    .p (add_p_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= '0;
      last_grant_q  <= 1'b1;
      c64_q         <= 1'b0;
      sum_lo_q      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_src   <= 1'b0;
      bus.rsp_sum   <= '0;
      bus.rsp_cout  <= 1'b0;
      bus.rsp_ovf   <= 1'b0;
    end else begin
      op_q <= op_d;
      case (state_q)
        ST_LO: begin
          sum_lo_q <= add_s_c;
          c64_q    <= add_cout_c;
        end
        ST_HI: begin
          bus.rsp_sum   <= {add_s_c, sum_lo_q};
          bus.rsp_cout  <= add_cout_c;
          bus.rsp_ovf   <= (op_q.a[FULL_W-1] == op_q.b[FULL_W-1]) &
                           (add_s_c[HALF_W-1] != op_q.a[FULL_W-1]);
          bus.rsp_src   <= op_q.src;
          bus.rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_hs_c) begin
            bus.rsp_valid <= 1'b0;
            last_grant_q  <= bus.rsp_src;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sched.sv
// Scoreboard bench for wide_add_sched: directed vectors, decoupled response monitor.
module tb_wide_add_sched;

  typedef struct packed {
    logic [127:0] a;
    logic [127:0] b;
    logic         sub;
  } tb_op_t;

  typedef struct packed {
    logic         src;
    logic         cout;
    logic         ovf;
    logic [127:0] sum;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  int   fp_cnt;
  bit   fp_done;

  tb_op_t ops0[$];
  tb_op_t ops1[$];
  exp_t   exp_q[$];
  int     hs_q[$];

  wide_add_sched_if bus ();
  wide_add_sched_if bus_fp ();

  wide_add_sched #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(bus));
  wide_add_sched #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [139:0] act, input logic [139:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic tb_op_t mkop(input logic [127:0] a, input logic [127:0] b, input logic sub);
    mkop = '{a: a, b: b, sub: sub};
  endfunction

  function automatic exp_t mkexp(input logic src, input logic cout, input logic ovf,
                                 input logic [127:0] sum);
    mkexp = '{src: src, cout: cout, ovf: ovf, sum: sum};
  endfunction

  task automatic drive0();
    @(negedge clk);
    while (ops0.size() > 0) begin
      int n;
      bus.req0_a = ops0[0].a; bus.req0_b = ops0[0].b; bus.req0_sub = ops0[0].sub;
      bus.req0_valid = 1'b1;
      #1; n = 0;
      while (!bus.req0_ready && n < 200) begin @(negedge clk); #1; n++; end
      if (!bus.req0_ready) begin
        check("req0_accept_timeout", 140'(bus.req0_ready), 140'(1));
        ops0.delete();
      end else begin
        hs_q.push_back(cyc);
        void'(ops0.pop_front());
        @(negedge clk);
      end
    end
    bus.req0_valid = 1'b0;
  endtask

  task automatic drive1();
    @(negedge clk);
    while (ops1.size() > 0) begin
      int n;
      bus.req1_a = ops1[0].a; bus.req1_b = ops1[0].b; bus.req1_sub = ops1[0].sub;
      bus.req1_valid = 1'b1;
      #1; n = 0;
      while (!bus.req1_ready && n < 200) begin @(negedge clk); #1; n++; end
      if (!bus.req1_ready) begin
        check("req1_accept_timeout", 140'(bus.req1_ready), 140'(1));
        ops1.delete();
      end else begin
        hs_q.push_back(cyc);
        void'(ops1.pop_front());
        @(negedge clk);
      end
    end
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ops0.size() != 0 || ops1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 140'(exp_q.size()), 140'(0));
    exp_q.delete();
    @(negedge clk); #1;
  endtask

  // Response monitor: latency on each rising rsp_valid, payload on each handshake.
  initial begin : monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.rsp_valid && !prev) begin
          if (hs_q.size() == 0) begin
            check("unexpected_rsp_valid", 140'(bus.rsp_valid), 140'(0));
          end else begin
            int hs;
            hs = hs_q.pop_front();
            check("latency", 140'(cyc - hs), 140'(3));
          end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 140'(bus.rsp_valid), 140'(0));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp", 140'({bus.rsp_src, bus.rsp_cout, bus.rsp_ovf, bus.rsp_sum}), 140'(e));
          end
        end
        prev = bus.rsp_valid;
      end
    end
  end

  initial begin : monitor_fp
    fp_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst && bus_fp.rsp_valid) begin
        fp_cnt++;
        check("fp_rsp", 140'({bus_fp.rsp_src, bus_fp.rsp_sum}), 140'({1'b0, 128'd3}));
      end
    end
  end

  // Fixed-priority instance: both requesters always pending, requester 0 must win every time.
  initial begin : fp_stim
    fp_done = 1'b0;
    bus_fp.req0_valid = 1'b0; bus_fp.req0_a = 128'd1;  bus_fp.req0_b = 128'd2;  bus_fp.req0_sub = 1'b0;
    bus_fp.req1_valid = 1'b0; bus_fp.req1_a = 128'd10; bus_fp.req1_b = 128'd20; bus_fp.req1_sub = 1'b0;
    bus_fp.rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus_fp.req0_valid = 1'b1;
    bus_fp.req1_valid = 1'b1;
    repeat (24) @(negedge clk);
    bus_fp.req0_valid = 1'b0;
    bus_fp.req1_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("fp_count_ge5", 140'(fp_cnt >= 5), 140'(1));
    fp_done = 1'b1;
  end

  initial begin : main
    logic [130:0] snap;
    logic         seen;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("reset_rsp", 140'({bus.rsp_valid, bus.rsp_src, bus.rsp_cout, bus.rsp_ovf, bus.rsp_sum}), 140'(0));
    check("reset_ready", 140'({bus.req0_ready, bus.req1_ready}), 140'(0));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;

    // Contention with round-robin: reset last_grant favours requester 0 first.
    ops0.push_back(mkop(128'h10, 128'h20, 1'b0));
    ops0.push_back(mkop({1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0));
    ops1.push_back(mkop(128'h100, 128'h1, 1'b1));
    ops1.push_back(mkop(128'd3, 128'd5, 1'b1));
    exp_q.push_back(mkexp(1'b0, 1'b0, 1'b0, 128'h30));
    exp_q.push_back(mkexp(1'b1, 1'b1, 1'b0, 128'hFF));
    exp_q.push_back(mkexp(1'b0, 1'b1, 1'b1, 128'h0));
    exp_q.push_back(mkexp(1'b1, 1'b0, 1'b0, {{127{1'b1}}, 1'b0}));
    fork drive0(); drive1(); join
    wait_drain();

    // Back-to-back requester 0 vectors: carry across halves, overflow, wrap, borrows.
    ops0.push_back(mkop(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0));
    exp_q.push_back(mkexp(1'b0, 1'b0, 1'b0, 128'h0000_0000_0000_0001_0000_0000_0000_0000));
    ops0.push_back(mkop({1'b0, {127{1'b1}}}, 128'd1, 1'b0));
    exp_q.push_back(mkexp(1'b0, 1'b0, 1'b1, {1'b1, 127'd0}));
    ops0.push_back(mkop({128{1'b1}}, 128'd1, 1'b0));
    exp_q.push_back(mkexp(1'b0, 1'b1, 1'b0, 128'd0));
    ops0.push_back(mkop(128'd5, 128'd3, 1'b1));
    exp_q.push_back(mkexp(1'b0, 1'b1, 1'b0, 128'd2));
    ops0.push_back(mkop({1'b1, 127'd0}, 128'd1, 1'b1));
    exp_q.push_back(mkexp(1'b0, 1'b1, 1'b1, {1'b0, {127{1'b1}}}));
    drive0();
    wait_drain();

    // Requester 1 subtract with borrow.
    ops1.push_back(mkop(128'd0, 128'd1, 1'b1));
    exp_q.push_back(mkexp(1'b1, 1'b0, 1'b0, {128{1'b1}}));
    drive1();
    wait_drain();

    // Consumer stall: response must hold and nobody is accepted.
    bus.rsp_ready = 1'b0;
    ops0.push_back(mkop(128'd2, 128'd3, 1'b0));
    ops0.push_back(mkop({128{1'b1}}, {128{1'b1}}, 1'b1));
    exp_q.push_back(mkexp(1'b0, 1'b0, 1'b0, 128'd5));
    exp_q.push_back(mkexp(1'b0, 1'b1, 1'b0, 128'd0));
    fork drive0(); join_none
    begin
      int n;
      n = 0;
      @(negedge clk); #1;
      while (!bus.rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
      check("stall_rsp_seen", 140'(bus.rsp_valid), 140'(1));
    end
    snap = {bus.rsp_src, bus.rsp_cout, bus.rsp_ovf, bus.rsp_sum};
    check("stall_snap", 140'(snap), 140'({1'b0, 1'b0, 1'b0, 128'd5}));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("stall_hold",
            140'({bus.rsp_valid, bus.req0_ready, bus.req1_ready,
                  bus.rsp_src, bus.rsp_cout, bus.rsp_ovf, bus.rsp_sum}),
            140'({1'b1, 1'b0, 1'b0, snap}));
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("release_idle_accept", 140'({bus.rsp_valid, bus.req0_ready}), 140'({1'b0, 1'b1}));
    wait_drain();

    // Reset while the operation sits in HI: result must be discarded.
    bus.req0_a = 128'd1; bus.req0_b = 128'd1; bus.req0_sub = 1'b0; bus.req0_valid = 1'b1;
    #1;
    check("rst_test_accept", 140'(bus.req0_ready), 140'(1));
    @(negedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    @(negedge clk); #1;
    check("rst_in_hi_outputs",
          140'({bus.rsp_valid, bus.rsp_src, bus.rsp_cout, bus.rsp_ovf, bus.rsp_sum,
                bus.req0_ready, bus.req1_ready}), 140'(0));
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      seen = seen | bus.rsp_valid;
    end
    check("rst_discard", 140'(seen), 140'(0));

    // Scheduler usable again after the mid-operation reset.
    ops1.push_back(mkop(128'd5, 128'd3, 1'b1));
    exp_q.push_back(mkexp(1'b1, 1'b1, 1'b0, 128'd2));
    drive1();
    wait_drain();

    begin
      int n;
      n = 0;
      while (!fp_done && n < 200) begin @(negedge clk); n++; end
      check("fp_finished", 140'(fp_done), 140'(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wide_add_sched.md
# wide_add_sched

Two-requester scheduler that shares one 64-bit lookahead-carry adder slice to perform 128-bit add/subtract operations over two cycles (low half, then high half with carried-in carry). It sits beside the M-extension datapath, where multiply-high accumulation and divide remainder correction both need occasional 128-bit sums but do not justify a dedicated 128-bit adder. Requests are arbitrated round-robin (or fixed priority), executed sequentially, and returned on a single tagged response port with valid/ready handshaking.

## Interface
Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  128 each  operands, requester 0
- req0_sub  in  1  1 = a − b, 0 = a + b
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_src  out  1  index of requester that issued the result
- rsp_sum  out  128  result
- rsp_cout  out  1  carry out of bit 127 (for sub: 1 = no borrow)
- rsp_ovf  out  1  signed two's-complement overflow

## Operation
- States: IDLE, LO, HI, RESP. Reset → IDLE.
- IDLE: grant = req0 if req0_valid and (!req1_valid or last_grant==1 or RR_EN==0); else req1 if req1_valid. reqN_ready = (state==IDLE) & grantN, combinational; at most one ready high. On handshake: latch a, b' = sub ? ~b : b, sub, src; → LO. No valid → stay IDLE.
- LO: adder on a[63:0], b'[63:0], cin = sub. Register sum_lo, c64 = g | (p & cin). → HI.
- HI: adder on a[127:64], b'[127:64], cin = c64. Register sum_hi, cout = g | (p & c64), ovf = (a[127]==b'[127]) & (sum[127]!=a[127]). → RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready. On rsp_valid & rsp_ready: last_grant ← rsp_src; → IDLE.
- No new request accepted outside IDLE; requests held by requester (valid must stay high with stable operands until ready).
- Width rules: all arithmetic modulo 2^128; sub uses inverted b plus cin=1 into the low half only.

## Timing
- Reset values: rsp_valid 0, rsp_src 0, rsp_sum 0, rsp_cout 0, rsp_ovf 0, req0_ready/req1_ready 0 on the reset cycle, last_grant 1 (requester 0 wins first contest).
- Latency: handshake at cycle T → rsp_valid high at T+3.
- Minimum issue interval 4 cycles (accept, LO, HI, RESP with immediate ready).
- Simultaneous valids: exactly one granted; with RR_EN=1 the other wins next IDLE if still valid.
- rsp_ready low: holds RESP indefinitely, no requester accepted.
- rst mid-operation (any state): next cycle IDLE, in-flight result discarded, outputs at reset values.
- rsp_ready asserted in IDLE/LO/HI: ignored.

## Structure
- Shared package: state encoding (IDLE=0, LO=1, HI=2, RESP=3), half width constant 64, full width 128.
- One sub-module instance: sixtyfourbit_lca (a, b, c, s, g, p), operand muxing between halves done in this block; carry combine g | (p & c) is local logic.

## Test plan
- req0 add a=0x0000…0000_FFFF_FFFF_FFFF_FFFF, b=1 → rsp_sum=0x…0001_0000_0000_0000_0000, cout 0, ovf 0, src 0, rsp_valid at T+3.
- req1 sub a=0, b=1 → rsp_sum=all ones, cout 0, ovf 0, src 1.
- add a=0x7FFF…FFFF, b=1 → rsp_sum=0x8000…0000, ovf 1; add all-ones + 1 → sum 0, cout 1, ovf 0.
- Both valid continuously, RR_EN=1 → grants alternate 0,1,0,1; RR_EN=0 → requester 0 every time.
- rsp_ready held low 10 cycles → rsp_* stable, req ready both 0; release → IDLE next cycle, next grant accepted.
- rst asserted in HI → following cycle rsp_valid 0, state IDLE, no response produced for that operation.
